// File: rtl/alu_operand_queue.sv
// First-word-fall-through operand queue feeding the 32-bit ALU; 1-cycle push-to-present, no empty bypass.
// Refuses pushes while full regardless of pops; head is held stable while alu_ready is low.
module alu_operand_queue #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_control,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  logic              in_fwd,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [2:0]        alu_control,
    output logic              alu_valid,
    input  logic              alu_ready,
    input  logic [WIDTH-1:0]  alu_result,
    output logic [WIDTH-1:0]  last_result,
    output logic [ADDR_W:0]   count
);

    typedef struct packed {
        logic [2:0]       ctrl;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             fwd;
    } entry_t;

    entry_t              r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_count;
    logic [WIDTH-1:0]    r_last;

    logic                w_push;
    logic                w_pop;
    entry_t              w_head;

    assign in_ready    = (r_count != (ADDR_W+1)'(DEPTH));
    assign alu_valid   = (r_count != '0);
    assign w_push      = in_valid && in_ready;
    assign w_pop       = alu_valid && alu_ready;
    assign count       = r_count;
    assign last_result = r_last;
    assign w_head      = r_mem[r_rd_ptr];

    // Forwarded ops read last_result live, so a chain of dependent ops resolves one per issue.
    always_comb begin
        alu_a       = '0;
        alu_b       = '0;
        alu_control = '0;
        if (alu_valid) begin
            alu_a       = w_head.fwd ? r_last : w_head.a;
            alu_b       = w_head.b;
            alu_control = w_head.ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_mem[r_wr_ptr] <= '{ctrl: in_control, a: in_a, b: in_b, fwd: in_fwd};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
                r_last   <= alu_result;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_operand_queue.sv
// Bench for alu_operand_queue: directed test-plan scenarios plus random traffic,
// checked every cycle against a queue-based reference model and a behavioural ALU.
module tb_alu_operand_queue;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_control;
    logic [WIDTH-1:0]  in_a;
    logic [WIDTH-1:0]  in_b;
    logic              in_fwd;
    logic [WIDTH-1:0]  alu_a;
    logic [WIDTH-1:0]  alu_b;
    logic [2:0]        alu_control;
    logic              alu_valid;
    logic              alu_ready;
    logic [WIDTH-1:0]  alu_result;
    logic [WIDTH-1:0]  last_result;
    logic [ADDR_W:0]   count;

    typedef struct {
        logic [2:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic        fwd;
    } op_t;

    op_t         mq[$];
    logic [31:0] m_last;
    int          n_assert = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(logic [2:0] c, logic [31:0] a, logic [31:0] b);
        case (c)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a ^ b;
            3'd3:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd4:    return a & b;
            3'd5:    return ~(a & b);
            3'd6:    return ~(a | b);
            default: return a | b;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_control, alu_a, alu_b);

    alu_operand_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_control(in_control),
        .in_a(in_a), .in_b(in_b), .in_fwd(in_fwd),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_result(alu_result),
        .last_result(last_result), .count(count)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_state(string tag);
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] ec;
        int          sz;
        sz = mq.size();
        ea = 0; eb = 0; ec = 0;
        if (sz > 0) begin
            ea = mq[0].fwd ? m_last : mq[0].a;
            eb = mq[0].b;
            ec = {29'd0, mq[0].ctrl};
        end
        chk({tag, ".count"},     {29'd0, count},           sz);
        chk({tag, ".alu_valid"}, {31'd0, alu_valid},       (sz != 0) ? 1 : 0);
        chk({tag, ".in_ready"},  {31'd0, in_ready},        (sz != DEPTH) ? 1 : 0);
        chk({tag, ".last"},      last_result,              m_last);
        chk({tag, ".alu_a"},     alu_a,                    ea);
        chk({tag, ".alu_b"},     alu_b,                    eb);
        chk({tag, ".alu_ctrl"},  {29'd0, alu_control},     ec);
    endtask

    // Model advances on the same edge as the DUT, using inputs held across the edge.
    task automatic tick(string tag);
        bit  push;
        bit  pop;
        bit  rst;
        op_t nop;
        op_t h;
        rst  = reset;
        push = in_valid && (mq.size() < DEPTH);
        pop  = alu_ready && (mq.size() > 0);
        nop  = '{ctrl: in_control, a: in_a, b: in_b, fwd: in_fwd};
        @(posedge clk);
        #1;
        if (rst) begin
            mq.delete();
            m_last = 0;
        end else begin
            if (pop) begin
                h = mq.pop_front();
                m_last = alu_fn(h.ctrl, h.fwd ? m_last : h.a, h.b);
            end
            if (push) mq.push_back(nop);
        end
        check_state(tag);
    endtask

    task automatic drive(logic v, logic [2:0] c, logic [31:0] a, logic [31:0] b, logic f);
        in_valid = v; in_control = c; in_a = a; in_b = b; in_fwd = f;
    endtask

    initial begin
        m_last = 0;
        reset = 1'b1; alu_ready = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        tick("reset0");
        tick("reset1");
        reset = 1'b0;

        // Single op
        alu_ready = 1'b1;
        drive(1'b1, 3'd0, 32'd1, 32'hFFFF_FFFB, 1'b0);
        tick("single.push");
        chk("single.alu_a_const", alu_a, 32'd1);
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        tick("single.pop");
        chk("single.last_const", last_result, 32'hFFFF_FFFC);

        // Forward chain
        drive(1'b1, 3'd0, 32'd1, 32'hFFFF_FFFB, 1'b0);
        tick("fwd.p0");
        drive(1'b1, 3'd1, 32'h0BAD_0BAD, 32'd3, 1'b1);
        tick("fwd.p1");
        chk("fwd.a1_const", alu_a, 32'hFFFF_FFFC);
        tick("fwd.p2");
        chk("fwd.a2_const", alu_a, 32'hFFFF_FFF9);
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        tick("fwd.drain");
        chk("fwd.last_const", last_result, 32'hFFFF_FFF6);

        // Full queue and backpressure; the 5th op is held until space opens
        alu_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3'd2, 32'd100 + i, 32'd10 + i, 1'b0);
            tick("full.push");
        end
        chk("full.in_ready_const", {31'd0, in_ready}, 32'd0);
        alu_ready = 1'b1;
        tick("full.pop_first");
        chk("full.b11_const", alu_b, 32'd11);
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 5; i++) tick("full.drain");

        // Simultaneous push/pop at count=2, then at count=4
        alu_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 3'd4, 32'hFFFF_0000, 32'd20 + i, 1'b0);
            tick("sim.fill");
        end
        alu_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'd7, 32'h0000_00F0, 32'd30 + i, 1'b0);
            tick("sim.pushpop");
            chk("sim.count2_const", {29'd0, count}, 32'd2);
        end
        alu_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 3'd6, 32'd5, 32'd40 + i, 1'b0);
            tick("sim.fill4");
        end
        alu_ready = 1'b1;
        tick("sim.full_pushpop");
        chk("sim.count3_const", {29'd0, count}, 32'd3);

        // Reset mid-stream with a push pending
        alu_ready = 1'b0;
        tick("rst.fill");
        reset = 1'b1;
        drive(1'b1, 3'd5, 32'd77, 32'd88, 1'b0);
        tick("rst.pulse");
        chk("rst.count_const", {29'd0, count}, 32'd0);
        chk("rst.last_const", last_result, 32'd0);
        reset = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        tick("rst.after");

        // Pointer wrap: 10 ops, alu_ready toggling every cycle
        begin
            int idx = 0;
            int cyc = 0;
            while ((idx < 10 || mq.size() > 0) && cyc < 200) begin
                alu_ready = cyc[0];
                if (idx < 10) drive(1'b1, 3'(idx % 8), 32'h1000 + idx, 32'h2000 + idx, 1'b0);
                else          drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
                if (idx < 10 && mq.size() < DEPTH) begin
                    tick("wrap");
                    idx++;
                end else begin
                    tick("wrap");
                end
                cyc++;
            end
            chk("wrap.all_issued", {31'd0, (mq.size() == 0 && idx == 10)}, 32'd1);
        end

        // Random traffic with occasional resets and forwarding
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(63) == 0);
            alu_ready = $urandom_range(1);
            drive($urandom_range(1), 3'($urandom_range(7)), $urandom, $urandom, $urandom_range(1));
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
